// File: rtl/bar_bank.sv
// Bank of NUM_BARS bouncing bars with keyboard-controlled step size, pause and resync.
// Heights update once per frame_clk edge; geometry other than height is constant.
module bar_bank #(
   parameter int NUM_BARS = 8,
   parameter int H_MIN    = 2,
   parameter int H_MAX    = 50,
   parameter int PHASE    = 12,
   parameter int STEP_MAX = 4,
   parameter int BAR_W    = 4,
   parameter int BAR_GAP  = 6,
   parameter int X_ORIGIN = 100,
   parameter int Y_BASE   = 240
) (
   input  logic                    Reset,
   input  logic                    frame_clk,
   input  logic [7:0]              keycode,
   output logic [10*NUM_BARS-1:0]  BarX,
   output logic [10*NUM_BARS-1:0]  BarY,
   output logic [10*NUM_BARS-1:0]  BarW,
   output logic [10*NUM_BARS-1:0]  BarH,
   output logic [3:0]              Speed,
   output logic                    Paused
);

   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_P = 8'h13;
   localparam logic [7:0] KEY_R = 8'h15;

   localparam logic [10:0] H_MIN_W    = 11'(H_MIN);
   localparam logic [10:0] H_MAX_W    = 11'(H_MAX);
   localparam logic [3:0]  STEP_MAX_W = 4'(STEP_MAX);

   function automatic logic [9:0] h_init(input int idx);
      return 10'(H_MIN + ((idx * PHASE) % (H_MAX - H_MIN)));
   endfunction

   logic [9:0]          h_q [NUM_BARS];
   logic [9:0]          h_d [NUM_BARS];
   logic [NUM_BARS-1:0] d_q, d_d;
   logic [3:0]          speed_q, speed_d;
   logic                paused_q, paused_d;
   logic [7:0]          key_q;

   logic key_new;
   logic ev_w, ev_s, ev_p, ev_r;

   assign key_new = (keycode != key_q);
   assign ev_w    = key_new && (keycode == KEY_W);
   assign ev_s    = key_new && (keycode == KEY_S);
   assign ev_p    = key_new && (keycode == KEY_P);
   assign ev_r    = key_new && (keycode == KEY_R);

   always_comb begin
      logic [10:0] sum;
      logic [10:0] floor_lim;
      for (int i = 0; i < NUM_BARS; i++) begin
         h_d[i] = h_q[i];
         d_d[i] = d_q[i];
      end
      speed_d  = speed_q;
      paused_d = paused_q;
      sum       = '0;
      floor_lim = H_MIN_W + 11'(speed_q);

      // Movement uses this edge's old speed/pause; resync then overrides it.
      if (ev_r) begin
         for (int i = 0; i < NUM_BARS; i++) begin
            h_d[i] = h_init(i);
            d_d[i] = 1'b1;
         end
         paused_d = 1'b0;
      end else begin
         if (!paused_q) begin
            for (int i = 0; i < NUM_BARS; i++) begin
               sum = {1'b0, h_q[i]} + 11'(speed_q);
               if (d_q[i]) begin
                  if (sum >= H_MAX_W) begin
                     h_d[i] = H_MAX_W[9:0];
                     d_d[i] = 1'b0;
                  end else begin
                     h_d[i] = sum[9:0];
                  end
               end else begin
                  if ({1'b0, h_q[i]} <= floor_lim) begin
                     h_d[i] = H_MIN_W[9:0];
                     d_d[i] = 1'b1;
                  end else begin
                     h_d[i] = h_q[i] - 10'(speed_q);
                  end
               end
            end
         end
         if (ev_p) paused_d = ~paused_q;
      end

      if (ev_w && (speed_q < STEP_MAX_W)) speed_d = speed_q + 4'd1;
      if (ev_s && (speed_q > 4'd1))       speed_d = speed_q - 4'd1;
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_BARS; i++) h_q[i] <= h_init(i);
         d_q      <= '1;
         speed_q  <= 4'd1;
         paused_q <= 1'b0;
         key_q    <= 8'h00;
      end else begin
         for (int i = 0; i < NUM_BARS; i++) h_q[i] <= h_d[i];
         d_q      <= d_d;
         speed_q  <= speed_d;
         paused_q <= paused_d;
         key_q    <= keycode;
      end
   end

   for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
      assign BarX[10*g +: 10] = 10'(X_ORIGIN + g * (BAR_W + BAR_GAP));
      assign BarY[10*g +: 10] = 10'(Y_BASE);
      assign BarW[10*g +: 10] = 10'(BAR_W);
      assign BarH[10*g +: 10] = h_q[g];
   end

   assign Speed  = speed_q;
   assign Paused = paused_q;

endmodule

// File: tb/tb_bar_bank.sv
// Bench for bar_bank: directed scenarios plus random keycodes, checked against
// a per-frame behavioural model of the bar motion and key handling.
module tb_bar_bank;
   localparam int NB = 4;
   localparam int HMIN = 2;
   localparam int HMAX = 50;
   localparam int PH = 12;
   localparam int SMAX = 4;

   logic             Reset;
   logic             frame_clk;
   logic [7:0]       keycode;
   logic [10*NB-1:0] BarX, BarY, BarW, BarH;
   logic [3:0]       Speed;
   logic             Paused;

   int total = 0;
   int bad = 0;

   int mh [NB];
   int md [NB];
   int mspd;
   int mpaused;
   int mprev;
   int frozen [NB];

   bar_bank #(.NUM_BARS(NB), .H_MIN(HMIN), .H_MAX(HMAX), .PHASE(PH), .STEP_MAX(SMAX),
              .BAR_W(4), .BAR_GAP(6), .X_ORIGIN(100), .Y_BASE(240)) dut (
      .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
      .BarX(BarX), .BarY(BarY), .BarW(BarW), .BarH(BarH),
      .Speed(Speed), .Paused(Paused));

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int bar_h(input int i);
      return int'(BarH[10*i +: 10]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         mh[i] = HMIN + ((i * PH) % (HMAX - HMIN));
         md[i] = 1;
      end
      mspd = 1;
      mpaused = 0;
      mprev = 0;
   endtask

   task automatic model_resync();
      for (int i = 0; i < NB; i++) begin
         mh[i] = HMIN + ((i * PH) % (HMAX - HMIN));
         md[i] = 1;
      end
      mpaused = 0;
   endtask

   // One frame of behaviour: bounce each bar by the old speed, then apply the key event.
   task automatic model_step(input int k);
      bit ev;
      ev = (k != mprev) && (k != 0);
      mprev = k;
      if (ev && k == 'h15) begin
         model_resync();
      end else begin
         if (mpaused == 0) begin
            for (int i = 0; i < NB; i++) begin
               if (md[i] == 1) begin
                  if (mh[i] + mspd >= HMAX) begin mh[i] = HMAX; md[i] = 0; end
                  else mh[i] = mh[i] + mspd;
               end else begin
                  if (mh[i] <= HMIN + mspd) begin mh[i] = HMIN; md[i] = 1; end
                  else mh[i] = mh[i] - mspd;
               end
            end
         end
         if (ev && k == 'h13) mpaused = 1 - mpaused;
      end
      if (ev && k == 'h1A) mspd = (mspd + 1 > SMAX) ? SMAX : mspd + 1;
      if (ev && k == 'h16) mspd = (mspd - 1 < 1) ? 1 : mspd - 1;
   endtask

   task automatic chk_model(input string tag);
      for (int i = 0; i < NB; i++) chk($sformatf("%s_h%0d", tag, i), 16'(bar_h(i)), 16'(mh[i]));
      chk({tag, "_speed"}, 16'(Speed), 16'(mspd));
      chk({tag, "_paused"}, 16'(Paused), 16'(mpaused));
   endtask

   task automatic tick(input logic [7:0] k, input string tag);
      keycode = k;
      @(posedge frame_clk);
      model_step(int'(k));
      #1;
      chk_model(tag);
   endtask

   task automatic press(input logic [7:0] k, input string tag);
      tick(k, tag);
      tick(8'h00, tag);
   endtask

   initial begin
      logic [7:0] k;
      int r;
      Reset = 1'b1;
      keycode = 8'h00;
      model_reset();
      repeat (3) @(posedge frame_clk);
      #2;
      chk("rst_h0", 16'(bar_h(0)), 16'd2);
      chk("rst_h1", 16'(bar_h(1)), 16'd14);
      chk("rst_h2", 16'(bar_h(2)), 16'd26);
      chk("rst_h3", 16'(bar_h(3)), 16'd38);
      chk("rst_speed", 16'(Speed), 16'd1);
      chk("rst_paused", 16'(Paused), 16'd0);
      for (int i = 0; i < NB; i++) begin
         chk($sformatf("barx%0d", i), 16'(BarX[10*i +: 10]), 16'(100 + 10 * i));
         chk($sformatf("bary%0d", i), 16'(BarY[10*i +: 10]), 16'd240);
         chk($sformatf("barw%0d", i), 16'(BarW[10*i +: 10]), 16'd4);
      end
      @(negedge frame_clk);
      Reset = 1'b0;

      // Twelve quiet frames take bar 3 to the ceiling; the thirteenth turns it around.
      for (int n = 0; n < 12; n++) tick(8'h00, "run");
      chk("ceil_bar3", 16'(bar_h(3)), 16'd50);
      tick(8'h00, "run13");
      chk("turn_bar3", 16'(bar_h(3)), 16'd49);
      chk("bar0_15", 16'(bar_h(0)), 16'd15);

      // Held key counts once per press.
      repeat (3) tick(8'h1A, "holdw");
      chk("speed2", 16'(Speed), 16'd2);
      tick(8'h00, "rel");
      repeat (4) tick(8'h1A, "holdw2");
      chk("speed3", 16'(Speed), 16'd3);
      tick(8'h00, "rel2");
      repeat (3) press(8'h1A, "satw");
      chk("speed_sat", 16'(Speed), 16'd4);
      repeat (5) press(8'h16, "floors");
      chk("speed_floor", 16'(Speed), 16'd1);
      press(8'h1A, "w");
      press(8'h1A, "w");

      // Pause freezes every bar for ten frames, then resumes from frozen heights.
      tick(8'h13, "pause");
      for (int i = 0; i < NB; i++) frozen[i] = mh[i];
      chk("paused_on", 16'(Paused), 16'd1);
      repeat (10) tick(8'h00, "frozen");
      for (int i = 0; i < NB; i++) chk($sformatf("frozen%0d", i), 16'(bar_h(i)), 16'(frozen[i]));
      tick(8'h13, "unpause");
      tick(8'h00, "resume");

      // Resync while paused restores phases but keeps speed.
      tick(8'h13, "pause2");
      tick(8'h00, "pause2b");
      tick(8'h15, "resync");
      chk("rs_h0", 16'(bar_h(0)), 16'd2);
      chk("rs_h3", 16'(bar_h(3)), 16'd38);
      chk("rs_paused", 16'(Paused), 16'd0);
      chk("rs_speed", 16'(Speed), 16'd3);
      tick(8'h00, "after_rs");

      // Random keycodes against the model.
      k = 8'h00;
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 19));
         if (r < 8) k = k;
         else if (r < 11) k = 8'h00;
         else if (r < 13) k = 8'h1A;
         else if (r < 15) k = 8'h16;
         else if (r == 15) k = 8'h13;
         else if (r == 16 && ($urandom_range(0, 3) == 0)) k = 8'h15;
         else if (r == 17) k = 8'($urandom_range(0, 255));
         else k = 8'h1A;
         tick(k, "rand");
      end

      // Reset mid-frame takes effect without waiting for an edge.
      @(negedge frame_clk);
      #2;
      Reset = 1'b1;
      #1;
      model_reset();
      chk_model("async_rst");
      chk("async_rst_h3", 16'(bar_h(3)), 16'd38);
      @(negedge frame_clk);
      Reset = 1'b0;
      keycode = 8'h00;
      tick(8'h00, "post_rst");
      chk("post_rst_h0", 16'(bar_h(0)), 16'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bar_bank.md
BAR_BANK -- requirements
Module: bar_bank

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_BARS, 8, bar channel count (1..16).
REQ-002 H_MIN, 2, lower height bound; H_MAX, 50, upper height bound; H_MIN < H_MAX <= 1023.
REQ-003 PHASE, 12, per-channel initial height offset; STEP_MAX, 4, maximum step (1..15).
REQ-004 BAR_W, 4, bar width; BAR_GAP, 6, gap between bars; X_ORIGIN, 100, bar 0 X; Y_BASE, 240, common bar Y.
REQ-005 Reset  input  1  reset Reset, asynchronous, active-high.
REQ-006 frame_clk  input  1  clock frame_clk, one rising edge per video frame.
REQ-007 keycode  input  8  current USB keycode, level, 0 = no key.
REQ-008 BarX, BarY, BarW, BarH  output  10*NUM_BARS each  packed per-bar geometry; bar i at bits [10i+9:10i].
REQ-009 Speed  output  4  current step size; Paused  output  1  freeze flag.

Function
REQ-010 BarX[i] SHALL equal X_ORIGIN + i*(BAR_W+BAR_GAP); BarY[i] SHALL equal Y_BASE; BarW[i] SHALL equal BAR_W; all constant, all 10-bit truncated.
REQ-011 Each bar SHALL hold a 10-bit height H[i] and a direction bit D[i] (1 = up); BarH[i] SHALL be H[i] registered, no combinational path from keycode.
REQ-012 Unpaused, per edge, D[i]=1: if H[i] + Speed >= H_MAX then H[i] <= H_MAX and D[i] <= 0, else H[i] <= H[i] + Speed.
REQ-013 Unpaused, per edge, D[i]=0: if H[i] <= H_MIN + Speed then H[i] <= H_MIN and D[i] <= 1, else H[i] <= H[i] - Speed.
REQ-014 H[i] SHALL never leave [H_MIN, H_MAX]; no overshoot, no wrap below 0; comparisons at 11-bit width.
REQ-015 Bars SHALL move in lockstep, one update per frame_clk edge, latency 0 frames from edge to BarH.
REQ-016 Key events SHALL be edge-detected: event when keycode differs from previous-frame keycode and equals a listed code; held key = one event.
REQ-017 Key 8'h1A (W): Speed <= min(Speed+1, STEP_MAX); 8'h16 (S): Speed <= max(Speed-1, 1).
REQ-018 Key 8'h13 (P): Paused toggles; while Paused, H[i] and D[i] SHALL hold.
REQ-019 Key 8'h15 (R): resync -- every H[i], D[i] to reset values, Paused <= 0; Speed unchanged.
REQ-020 Speed change on edge N SHALL first affect movement on edge N+1; edge N uses old Speed.
REQ-021 Resync on edge N SHALL override that edge's movement; pause toggle on edge N takes effect from edge N+1.
REQ-022 Unlisted keycodes and transitions to 0 SHALL have no effect.

Reset
REQ-023 On Reset: H[i] = H_MIN + ((i*PHASE) mod (H_MAX-H_MIN)), D[i] = 1, Speed = 1, Paused = 0, previous-keycode register = 0.
REQ-024 Reset SHALL act asynchronously mid-frame and mid-movement; first movement on first edge after deassertion.

Verification (NUM_BARS=4, H_MIN=2, H_MAX=50, PHASE=12, STEP_MAX=4)
REQ-025 Reset -> BarH = {2,14,26,38}, Speed=1, Paused=0, BarX = {100,110,120,130}, BarY = 240 all.
REQ-026 Release, 12 edges, keycode 0 -> bar3 = 50 with D=0; edge 13 -> bar3 = 49; bar0 = 15.
REQ-027 keycode 8'h1A held 3 frames then 0, then 8'h1A again 4 frames -> Speed 2 then 3; repeated presses saturate at 4, 8'h16 x5 floors at 1.
REQ-028 Speed=4, bar at 48 D=1 -> next edge 50, D=0, next edge 46; bar at 5 D=0 -> 2, D=1.
REQ-029 8'h13 pulse -> BarH frozen 10 frames; second 8'h13 -> movement resumes next edge from frozen values.
REQ-030 Paused with 8'h15 pulse -> BarH = {2,14,26,38}, Paused=0, Speed retained; Reset asserted mid-run -> immediate reset values.
